operand_fetch: RTL

- Decode/operand-fetch stage that sits directly upstream of reg_file and feeds the execute stage.
- Accepts RV32I instructions over a valid/ready handshake and drives the reg_file read addresses.
- Captures read data into a single-entry ID/EX pipeline register, with writeback bypass.
- Tracks in-flight destination registers in a busy scoreboard and stalls on RAW and WAW hazards.

---
 rtl/opf_pkg.sv | 44 ++++
 rtl/opf_scoreboard.sv | 49 ++++
 rtl/operand_fetch.sv | 113 +++++++++++
 3 files changed

// File: rtl/opf_pkg.sv
// Shared opcodes and decode helper for the operand-fetch stage.
package opf_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } dec_t;

    // Unknown opcodes decode to no operands and no destination.
    function automatic dec_t decode(input logic [6:0] opcode);
        dec_t d;
        d = '0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: d.writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                d.uses_rs1  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OP_REG: begin
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/opf_scoreboard.sv
// Busy bit per architectural register; OPF_WB_BYPASS_EN lets a same-cycle clear count as free.
module opf_scoreboard
    import opf_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] qaddr1,
    input  logic [REG_AW-1:0] qaddr2,
    input  logic [REG_AW-1:0] qaddr3,
    output logic              busy1_c,
    output logic              busy2_c,
    output logic              busy3_c
);

    localparam int unsigned NREG = 1 << REG_AW;

    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    // Clear first so a coincident set wins; x0 can never become busy.
    always_comb begin
        sb_next = sb;
        if (clr_en) sb_next[clr_addr] = 1'b0;
        if (set_en) sb_next[set_addr] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) sb <= '0;
        else        sb <= sb_next;
    end

`ifdef OPF_WB_BYPASS_EN
    assign busy1_c = sb[qaddr1] && !(clr_en && (clr_addr == qaddr1));
    assign busy2_c = sb[qaddr2] && !(clr_en && (clr_addr == qaddr2));
    assign busy3_c = sb[qaddr3] && !(clr_en && (clr_addr == qaddr3));
`else
    assign busy1_c = sb[qaddr1];
    assign busy2_c = sb[qaddr2];
    assign busy3_c = sb[qaddr3];
`endif

endmodule

// File: rtl/operand_fetch.sv
// RV32I decode/operand-fetch stage with busy scoreboard and single-entry ID/EX register.
// Build option OPF_WB_BYPASS_EN enables same-cycle writeback bypass and busy clear.
module operand_fetch
    import opf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inst_valid_in,
    input  logic [XLEN-1:0]   inst_in,
    input  logic [XLEN-1:0]   pc_in,
    output logic              inst_ready_out,
    output logic [REG_AW-1:0] rf_raddr1_out,
    output logic [REG_AW-1:0] rf_raddr2_out,
    input  logic [XLEN-1:0]   rf_rdata1_in,
    input  logic [XLEN-1:0]   rf_rdata2_in,
    input  logic              wb_we_in,
    input  logic [REG_AW-1:0] wb_waddr_in,
    input  logic [XLEN-1:0]   wb_wdata_in,
    output logic              ex_valid_out,
    input  logic              ex_ready_in,
    output logic [XLEN-1:0]   ex_pc_out,
    output logic [XLEN-1:0]   ex_inst_out,
    output logic [XLEN-1:0]   ex_rs1_data_out,
    output logic [XLEN-1:0]   ex_rs2_data_out,
    output logic [REG_AW-1:0] ex_rd_out
);

    logic [REG_AW-1:0] rs1, rs2, rd;
    dec_t              dec;
    logic              rd_wr;
    logic              busy1, busy2, busy3;
    logic              hazard;
    logic              accept;
    logic [XLEN-1:0]   op1, op2;

    assign rs1   = REG_AW'(inst_in[19:15]);
    assign rs2   = REG_AW'(inst_in[24:20]);
    assign rd    = REG_AW'(inst_in[11:7]);
    assign dec   = decode(inst_in[6:0]);
    assign rd_wr = dec.writes_rd && (rd != '0);

    assign rf_raddr1_out = rs1;
    assign rf_raddr2_out = rs2;

    opf_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clock    (clock),
        .reset    (reset),
        .set_en   (accept && rd_wr),
        .set_addr (rd),
        .clr_en   (wb_we_in),
        .clr_addr (wb_waddr_in),
        .qaddr1   (rs1),
        .qaddr2   (rs2),
        .qaddr3   (rd),
        .busy1_c  (busy1),
        .busy2_c  (busy2),
        .busy3_c  (busy3)
    );

    // Last term is the WAW stall on an in-flight destination.
    assign hazard = (dec.uses_rs1 && busy1) ||
                    (dec.uses_rs2 && busy2) ||
                    (rd_wr && busy3);

    assign inst_ready_out = reset && (!ex_valid_out || ex_ready_in) && !hazard;
    assign accept         = inst_valid_in && inst_ready_out;

    // x0 override is applied last so it beats any bypass hit.
    always_comb begin
        op1 = rf_rdata1_in;
`ifdef OPF_WB_BYPASS_EN
        if (wb_we_in && (wb_waddr_in == rs1)) op1 = wb_wdata_in;
`endif
        if (rs1 == '0) op1 = '0;
    end

    always_comb begin
        op2 = rf_rdata2_in;
`ifdef OPF_WB_BYPASS_EN
        if (wb_we_in && (wb_waddr_in == rs2)) op2 = wb_wdata_in;
`endif
        if (rs2 == '0) op2 = '0;
    end

`ifndef OPF_WB_BYPASS_EN
    logic unused_wdata;
    assign unused_wdata = ^wb_wdata_in;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_valid_out    <= 1'b0;
            ex_pc_out       <= '0;
            ex_inst_out     <= '0;
            ex_rs1_data_out <= '0;
            ex_rs2_data_out <= '0;
            ex_rd_out       <= '0;
        end else if (accept) begin
            ex_valid_out    <= 1'b1;
            ex_pc_out       <= pc_in;
            ex_inst_out     <= inst_in;
            ex_rs1_data_out <= op1;
            ex_rs2_data_out <= op2;
            ex_rd_out       <= rd_wr ? rd : '0;
        end else if (ex_ready_in) begin
            ex_valid_out    <= 1'b0;
        end
    end

endmodule
